// File: rtl/cicero_cmd_executor.sv
// cicero_cmd_executor
// System-clock-side executor for host debug commands. The host writes a
// command word from the tck domain; this block synchronizes it, runs one
// command at a time against instruction memory or the regex engine, and
// publishes results through the status and data_out registers. The host
// flips command[31] for every new command and polls status[4] until it
// matches, so a stale or repeated command word never executes twice.

module cicero_cmd_executor #(
    parameter int MEM_ADDR_W = 9,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           command,
    input  logic [31:0]           address,
    input  logic [31:0]           start_cc_pointer,
    input  logic [31:0]           end_cc_pointer,
    input  logic [63:0]           data_in,
    output logic [31:0]           status,
    output logic [63:0]           data_out,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [63:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [63:0]           mem_rdata,
    output logic                  eng_start,
    output logic                  eng_reset,
    output logic [31:0]           eng_start_cc,
    output logic [31:0]           eng_end_cc,
    input  logic                  eng_busy,
    input  logic                  eng_done,
    input  logic                  eng_accept
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [3:0] OP_NOP          = 4'd0;
    localparam logic [3:0] OP_WRITE_MEM    = 4'd1;
    localparam logic [3:0] OP_READ_MEM     = 4'd2;
    localparam logic [3:0] OP_START        = 4'd3;
    localparam logic [3:0] OP_RESET_ENGINE = 4'd4;
    localparam logic [3:0] OP_CLEAR_STATUS = 4'd5;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating increment for the engine-run cycle counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + CNT_ONE;
        end
        return result;
    endfunction

    // Command synchronizer: two flops into the clk domain plus a history flop.
    logic [31:0] cmd_s1_q;
    logic [31:0] cmd_s2_q;
    logic [31:0] cmd_s3_q;

    // Control state and status fields.
    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic             accept_q;
    logic             error_q;
    logic             ack_toggle_q;
    logic [3:0]       last_op_q;
    logic [CNT_W-1:0] counter_q;

    // Command held while a multi-cycle operation is in flight.
    logic [3:0]       cur_op_q;
    logic             cur_toggle_q;

    // Registered outputs.
    logic [63:0]           data_out_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [MEM_ADDR_W-1:0] mem_addr_q;
    logic [63:0]           mem_wdata_q;
    logic                  eng_start_q;
    logic                  eng_reset_q;
    logic [31:0]           start_cc_q;
    logic [31:0]           end_cc_q;

    // Acceptance decode.
    logic       cmd_valid_s;
    logic [3:0] cmd_op_s;
    logic       cmd_toggle_s;
    logic       addr_ok_s;
    logic       start_ok_s;

    // Bring the host command into the clk domain and keep one cycle of history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_s1_q <= 32'd0;
            cmd_s2_q <= 32'd0;
            cmd_s3_q <= 32'd0;
        end else begin
            cmd_s1_q <= command;
            cmd_s2_q <= cmd_s1_q;
            cmd_s3_q <= cmd_s2_q;
        end
    end

    // Decide whether the synchronized command is new, stable and may start now.
    always_comb begin
        cmd_op_s     = cmd_s2_q[3:0];
        cmd_toggle_s = cmd_s2_q[31];
        addr_ok_s    = ((address >> MEM_ADDR_W) == 32'd0);
        start_ok_s   = (eng_busy == 1'b0) && (start_cc_pointer <= end_cc_pointer);
        if ((state_q == ST_IDLE) && (cmd_s2_q == cmd_s3_q) &&
            (cmd_toggle_s != ack_toggle_q)) begin
            cmd_valid_s = 1'b1;
        end else begin
            cmd_valid_s = 1'b0;
        end
    end

    // Command FSM: dispatch, memory handshake, engine run and status updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            accept_q     <= 1'b0;
            error_q      <= 1'b0;
            ack_toggle_q <= 1'b0;
            last_op_q    <= 4'd0;
            counter_q    <= {CNT_W{1'b0}};
            cur_op_q     <= 4'd0;
            cur_toggle_q <= 1'b0;
            data_out_q   <= 64'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {MEM_ADDR_W{1'b0}};
            mem_wdata_q  <= 64'd0;
            eng_start_q  <= 1'b0;
            eng_reset_q  <= 1'b0;
            start_cc_q   <= 32'd0;
            end_cc_q     <= 32'd0;
        end else begin
            // Engine strobes are single-cycle unless re-armed below.
            eng_start_q <= 1'b0;
            eng_reset_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_s) begin
                        // Operands are stable by host protocol; capture them now.
                        cur_op_q     <= cmd_op_s;
                        cur_toggle_q <= cmd_toggle_s;
                        mem_addr_q   <= address[MEM_ADDR_W-1:0];
                        mem_wdata_q  <= data_in;
                        start_cc_q   <= start_cc_pointer;
                        end_cc_q     <= end_cc_pointer;
                        case (cmd_op_s)
                            OP_WRITE_MEM, OP_READ_MEM: begin
                                if (addr_ok_s) begin
                                    state_q   <= ST_MEM;
                                    busy_q    <= 1'b1;
                                    mem_req_q <= 1'b1;
                                    mem_we_q  <= (cmd_op_s == OP_WRITE_MEM);
                                end else begin
                                    error_q      <= 1'b1;
                                    ack_toggle_q <= cmd_toggle_s;
                                    last_op_q    <= cmd_op_s;
                                end
                            end
                            OP_START: begin
                                if (start_ok_s) begin
                                    state_q     <= ST_RUN;
                                    busy_q      <= 1'b1;
                                    eng_start_q <= 1'b1;
                                end else begin
                                    error_q      <= 1'b1;
                                    ack_toggle_q <= cmd_toggle_s;
                                    last_op_q    <= cmd_op_s;
                                end
                            end
                            OP_NOP: begin
                                ack_toggle_q <= cmd_toggle_s;
                                last_op_q    <= cmd_op_s;
                            end
                            OP_RESET_ENGINE: begin
                                eng_reset_q  <= 1'b1;
                                done_q       <= 1'b0;
                                accept_q     <= 1'b0;
                                ack_toggle_q <= cmd_toggle_s;
                                last_op_q    <= cmd_op_s;
                            end
                            OP_CLEAR_STATUS: begin
                                done_q       <= 1'b0;
                                accept_q     <= 1'b0;
                                error_q      <= 1'b0;
                                counter_q    <= {CNT_W{1'b0}};
                                ack_toggle_q <= cmd_toggle_s;
                                last_op_q    <= cmd_op_s;
                            end
                            default: begin
                                // Opcodes 6..15 are illegal.
                                error_q      <= 1'b1;
                                ack_toggle_q <= cmd_toggle_s;
                                last_op_q    <= cmd_op_s;
                            end
                        endcase
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        if (!mem_we_q) begin
                            data_out_q <= mem_rdata;
                        end else begin
                            data_out_q <= data_out_q;
                        end
                        mem_req_q    <= 1'b0;
                        mem_we_q     <= 1'b0;
                        state_q      <= ST_IDLE;
                        busy_q       <= 1'b0;
                        ack_toggle_q <= cur_toggle_q;
                        last_op_q    <= cur_op_q;
                    end else begin
                        mem_req_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Every RUN cycle counts, including the one carrying eng_done.
                    counter_q <= sat_inc(counter_q);
                    if (eng_done) begin
                        accept_q     <= eng_accept;
                        done_q       <= 1'b1;
                        state_q      <= ST_IDLE;
                        busy_q       <= 1'b0;
                        ack_toggle_q <= cur_toggle_q;
                        last_op_q    <= cur_op_q;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    busy_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign status       = {counter_q, 4'd0, last_op_q, 3'd0,
                           ack_toggle_q, error_q, accept_q, done_q, busy_q};
    assign data_out     = data_out_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign eng_start    = eng_start_q;
    assign eng_reset    = eng_reset_q;
    assign eng_start_cc = start_cc_q;
    assign eng_end_cc   = end_cc_q;

endmodule

// File: tb/tb_cicero_cmd_executor.sv
// Self-checking bench for cicero_cmd_executor: directed scenarios plus a
// randomized command stream checked against a command-level status model.

module tb_cicero_cmd_executor;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   command = 32'd0;
    logic [31:0]   address = 32'd0;
    logic [31:0]   start_cc_pointer = 32'd0;
    logic [31:0]   end_cc_pointer = 32'd0;
    logic [63:0]   data_in = 64'd0;
    logic [31:0]   status;
    logic [63:0]   data_out;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_wdata;
    logic          mem_ack = 1'b0;
    logic [63:0]   mem_rdata = 64'd0;
    logic          eng_start;
    logic          eng_reset;
    logic [31:0]   eng_start_cc;
    logic [31:0]   eng_end_cc;
    logic          eng_busy = 1'b0;
    logic          eng_done = 1'b0;
    logic          eng_accept = 1'b0;

    int total = 0;
    int bad = 0;

    // Command-level model of the host-visible state.
    bit          m_done, m_acc, m_err, m_ack;
    logic [3:0]  m_lop;
    int          m_cnt;
    logic [63:0] m_dout;

    // Observations gathered while a command executes.
    int            n_req, n_start, n_reset;
    logic [AW-1:0] o_addr;
    logic          o_we;
    logic [63:0]   o_wdata;
    logic [31:0]   o_scc, o_ecc;
    bit            timed_out;

    cicero_cmd_executor #(.MEM_ADDR_W(AW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .command(command), .address(address),
        .start_cc_pointer(start_cc_pointer), .end_cc_pointer(end_cc_pointer),
        .data_in(data_in), .status(status), .data_out(data_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .eng_start(eng_start), .eng_reset(eng_reset),
        .eng_start_cc(eng_start_cc), .eng_end_cc(eng_end_cc),
        .eng_busy(eng_busy), .eng_done(eng_done), .eng_accept(eng_accept)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_status();
        logic [31:0] cnt;
        cnt = m_cnt;
        return {cnt[15:0], 4'd0, m_lop, 3'd0, m_ack, m_err, m_acc, m_done, 1'b0};
    endfunction

    task automatic model_clear();
        m_done = 0; m_acc = 0; m_err = 0; m_ack = 0; m_lop = 4'd0; m_cnt = 0; m_dout = 64'd0;
    endtask

    // Apply one completed command to the model using the documented rules.
    task automatic model_apply(input logic [31:0] cmd, input logic [31:0] addr,
                               input logic [31:0] scc, input logic [31:0] ecc,
                               input bit busy_in, input int run_len, input bit acc,
                               input logic [63:0] rdata);
        bit addr_ok;
        addr_ok = (longint'(addr) < (longint'(1) << AW));
        case (int'(cmd[3:0]))
            0: ;
            1: if (!addr_ok) m_err = 1;
            2: if (!addr_ok) m_err = 1; else m_dout = rdata;
            3: if (busy_in || scc > ecc) m_err = 1;
               else begin
                   m_cnt = (m_cnt + run_len > 65535) ? 65535 : m_cnt + run_len;
                   m_done = 1; m_acc = acc;
               end
            4: begin m_done = 0; m_acc = 0; end
            5: begin m_done = 0; m_acc = 0; m_err = 0; m_cnt = 0; end
            default: m_err = 1;
        endcase
        m_ack = cmd[31];
        m_lop = cmd[3:0];
    endtask

    // Issue a command and act as memory and engine until the host sees the ack.
    task automatic run_cmd(input logic [31:0] cmd, input int ack_dly, input int run_len,
                           input bit acc, input logic [63:0] rdata, input int max_cyc);
        int mem_cnt;
        int run_cnt;
        mem_cnt = 0; run_cnt = 0;
        n_req = 0; n_start = 0; n_reset = 0; timed_out = 1;
        command = cmd;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge clk);
            mem_ack = 1'b0; eng_done = 1'b0; eng_accept = 1'b0;
            if (mem_req) begin
                if (mem_cnt == 0) begin
                    n_req++; o_addr = mem_addr; o_we = mem_we; o_wdata = mem_wdata;
                end
                if (mem_cnt == ack_dly) begin mem_ack = 1'b1; mem_rdata = rdata; end
                mem_cnt++;
            end
            if (eng_start) begin
                n_start++; o_scc = eng_start_cc; o_ecc = eng_end_cc; eng_busy = 1'b1;
            end
            if (eng_reset) n_reset++;
            if (n_start > 0 && status[0]) begin
                run_cnt++;
                if (run_cnt == run_len) begin
                    eng_done = 1'b1; eng_accept = acc; eng_busy = 1'b0;
                end
            end
            if (status[4] == cmd[31] && !status[0]) begin
                timed_out = 0;
                break;
            end
        end
        // One trailing cycle: any further strobe is unexpected activity.
        @(negedge clk);
        mem_ack = 1'b0; eng_done = 1'b0; eng_accept = 1'b0;
        if (mem_req) n_req++;
        if (eng_start) n_start++;
        if (eng_reset) n_reset++;
    endtask

    task automatic test_reset();
        int act;
        act = 0;
        rst = 1'b1; command = 32'd0;
        repeat (3) @(negedge clk);
        total++;
        if ({status, data_out, mem_req, mem_we, mem_addr, mem_wdata, eng_start, eng_reset,
             eng_start_cc, eng_end_cc} !== '0) begin
            bad++; $display("FAIL reset_outputs: got status=%h data_out=%h mem_req=%b want all zero",
                            status, data_out, mem_req);
        end
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_req || eng_start || eng_reset || status != 32'd0) act++;
        end
        total++;
        if (act !== 0) begin
            bad++; $display("FAIL idle_zero_cmd: got %0d active cycles want 0", act);
        end
    endtask

    task automatic test_write();
        address = 32'd5; data_in = 64'h1122334455667788;
        run_cmd(32'h8000_0001, 4, 0, 0, 64'd0, 300);
        model_apply(32'h8000_0001, address, 32'd0, 32'd0, 0, 0, 0, 64'd0);
        total++; if (timed_out) begin bad++; $display("FAIL write_ack: got timeout want ack"); end
        total++; if (n_req !== 1) begin bad++; $display("FAIL write_req: got %0d want 1", n_req); end
        total++; if ({o_we, o_addr} !== {1'b1, 9'd5}) begin
            bad++; $display("FAIL write_we_addr: got we=%b addr=%0d want we=1 addr=5", o_we, o_addr);
        end
        total++; if (o_wdata !== 64'h1122334455667788) begin
            bad++; $display("FAIL write_wdata: got %h want 1122334455667788", o_wdata);
        end
        total++; if (status !== 32'h0000_0110) begin
            bad++; $display("FAIL write_status: got %h want 00000110", status);
        end
    endtask

    task automatic test_read();
        address = 32'd5;
        run_cmd(32'h0000_0002, 2, 0, 0, 64'hDEADBEEF_00C0FFEE, 300);
        model_apply(32'h0000_0002, address, 32'd0, 32'd0, 0, 0, 0, 64'hDEADBEEF_00C0FFEE);
        total++; if (timed_out || n_req !== 1 || o_we !== 1'b0) begin
            bad++; $display("FAIL read_req: got timeout=%0d req=%0d we=%b want 0 1 0", timed_out, n_req, o_we);
        end
        total++; if (data_out !== 64'hDEADBEEF_00C0FFEE) begin
            bad++; $display("FAIL read_data: got %h want deadbeef00c0ffee", data_out);
        end
        total++; if (status[4] !== 1'b0 || status[11:8] !== 4'd2) begin
            bad++; $display("FAIL read_status: got %h want ack=0 last_op=2", status);
        end
    endtask

    task automatic test_run();
        start_cc_pointer = 32'h10; end_cc_pointer = 32'h40;
        run_cmd(32'h8000_0003, 0, 20, 1, 64'd0, 300);
        model_apply(32'h8000_0003, address, 32'h10, 32'h40, 0, 20, 1, 64'd0);
        total++; if (timed_out || n_start !== 1) begin
            bad++; $display("FAIL run_start: got timeout=%0d starts=%0d want 0 1", timed_out, n_start);
        end
        total++; if (o_scc !== 32'h10 || o_ecc !== 32'h40) begin
            bad++; $display("FAIL run_ptrs: got %h %h want 10 40", o_scc, o_ecc);
        end
        total++; if (status !== 32'h0014_0316) begin
            bad++; $display("FAIL run_status: got %h want 00140316", status);
        end
    endtask

    task automatic test_errors();
        start_cc_pointer = 32'h40; end_cc_pointer = 32'h10;
        run_cmd(32'h0000_0003, 0, 5, 0, 64'd0, 300);
        model_apply(32'h0000_0003, address, 32'h40, 32'h10, 0, 5, 0, 64'd0);
        total++; if (n_start !== 0 || status[3] !== 1'b1 || status !== exp_status()) begin
            bad++; $display("FAIL err_start_order: got starts=%0d status=%h want 0 %h", n_start, status, exp_status());
        end
        run_cmd(32'h8000_0009, 0, 0, 0, 64'd0, 300);
        model_apply(32'h8000_0009, address, 32'd0, 32'd0, 0, 0, 0, 64'd0);
        total++; if (status[3] !== 1'b1 || status !== exp_status()) begin
            bad++; $display("FAIL err_illegal_op: got %h want %h", status, exp_status());
        end
        address = 32'h200;
        run_cmd(32'h0000_0001, 0, 0, 0, 64'd0, 300);
        model_apply(32'h0000_0001, 32'h200, 32'd0, 32'd0, 0, 0, 0, 64'd0);
        total++; if (n_req !== 0 || status !== exp_status()) begin
            bad++; $display("FAIL err_addr_range: got req=%0d status=%h want 0 %h", n_req, status, exp_status());
        end
        run_cmd(32'h8000_0005, 0, 0, 0, 64'd0, 300);
        model_apply(32'h8000_0005, 32'd0, 32'd0, 32'd0, 0, 0, 0, 64'd0);
        total++; if (status !== 32'h0000_0510) begin
            bad++; $display("FAIL clear_status: got %h want 00000510", status);
        end
    endtask

    task automatic test_pending();
        bit t;
        int resets;
        bit seen;
        t = ~m_ack; resets = 0; seen = 0;
        address = 32'd3;
        command = {t, 27'd0, 4'd2};
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (mem_req) seen = 1;
        end
        command = {~t, 27'd0, 4'd4};
        repeat (6) @(negedge clk);
        command = {~t, 27'd0, 4'd0};
        repeat (6) @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        mem_ack = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (eng_reset) resets++;
            if (status[4] == ~t && !status[0] && status[11:8] == 4'd0) begin seen = 1; break; end
        end
        repeat (3) @(negedge clk);
        model_apply({t, 27'd0, 4'd2}, 32'd3, 32'd0, 32'd0, 0, 0, 0, 64'h0123_4567_89AB_CDEF);
        model_apply({~t, 27'd0, 4'd0}, 32'd3, 32'd0, 32'd0, 0, 0, 0, 64'd0);
        total++; if (!seen || resets !== 0) begin
            bad++; $display("FAIL pending_latest: got seen=%0d resets=%0d want 1 0", seen, resets);
        end
        total++; if (status !== exp_status() || data_out !== m_dout) begin
            bad++; $display("FAIL pending_status: got %h %h want %h %h", status, data_out, exp_status(), m_dout);
        end
    endtask

    task automatic test_random();
        logic [31:0] cmd, scc, ecc, addr;
        logic [63:0] rdata;
        int op, dly, len;
        bit busy, acc, addr_ok;
        int exp_req, exp_start, exp_reset;
        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 5);
            addr = ($urandom_range(0, 6) == 0) ? (32'h200 | $urandom) : $urandom_range(0, 511);
            scc = $urandom_range(1, 1000);
            case ($urandom_range(0, 4))
                0: ecc = $urandom_range(0, scc - 1);
                1: ecc = scc;
                default: ecc = scc + $urandom_range(0, 1000);
            endcase
            busy = (op == 3) && ($urandom_range(0, 5) == 0);
            acc = $urandom_range(0, 1);
            dly = $urandom_range(0, 5);
            len = $urandom_range(1, 30);
            rdata = {$urandom, $urandom};
            cmd = {~m_ack, 27'($urandom), 4'(op)};
            address = addr; start_cc_pointer = scc; end_cc_pointer = ecc;
            data_in = {$urandom, $urandom};
            eng_busy = busy;
            run_cmd(cmd, dly, len, acc, rdata, 300);
            eng_busy = 1'b0;
            addr_ok = (addr < 32'd512);
            exp_req = ((op == 1 || op == 2) && addr_ok) ? 1 : 0;
            exp_start = (op == 3 && !busy && scc <= ecc) ? 1 : 0;
            exp_reset = (op == 4) ? 1 : 0;
            model_apply(cmd, addr, scc, ecc, busy, len, acc, rdata);
            total++; if (timed_out || status !== exp_status()) begin
                bad++; $display("FAIL rand_status[%0d]: got %h timeout=%0d want %h", n, status, timed_out, exp_status());
            end
            total++; if (data_out !== m_dout) begin
                bad++; $display("FAIL rand_data[%0d]: got %h want %h", n, data_out, m_dout);
            end
            total++; if (n_req !== exp_req || n_start !== exp_start || n_reset !== exp_reset) begin
                bad++; $display("FAIL rand_strobes[%0d]: got %0d %0d %0d want %0d %0d %0d",
                                n, n_req, n_start, n_reset, exp_req, exp_start, exp_reset);
            end
            if (exp_req == 1) begin
                total++; if (o_addr !== addr[AW-1:0] || o_we !== (op == 1) || (op == 1 && o_wdata !== data_in)) begin
                    bad++; $display("FAIL rand_mem[%0d]: got a=%0d we=%b d=%h want a=%0d op=%0d d=%h",
                                    n, o_addr, o_we, o_wdata, addr[AW-1:0], op, data_in);
                end
            end
            if (exp_start == 1) begin
                total++; if (o_scc !== scc || o_ecc !== ecc) begin
                    bad++; $display("FAIL rand_ptrs[%0d]: got %h %h want %h %h", n, o_scc, o_ecc, scc, ecc);
                end
            end
        end
    endtask

    task automatic test_saturate();
        logic [31:0] cmd;
        cmd = {~m_ack, 27'd0, 4'd5};
        run_cmd(cmd, 0, 0, 0, 64'd0, 300);
        model_apply(cmd, 32'd0, 32'd0, 32'd0, 0, 0, 0, 64'd0);
        start_cc_pointer = 32'd0; end_cc_pointer = 32'd0;
        cmd = {~m_ack, 27'd0, 4'd3};
        run_cmd(cmd, 0, 65540, 0, 64'd0, 70000);
        model_apply(cmd, 32'd0, 32'd0, 32'd0, 0, 65540, 0, 64'd0);
        total++; if (timed_out || status[31:16] !== 16'hFFFF || status !== exp_status()) begin
            bad++; $display("FAIL counter_saturate: got %h want %h", status, exp_status());
        end
        cmd = {~m_ack, 27'd0, 4'd3};
        run_cmd(cmd, 0, 5, 1, 64'd0, 300);
        model_apply(cmd, 32'd0, 32'd0, 32'd0, 0, 5, 1, 64'd0);
        total++; if (status !== exp_status()) begin
            bad++; $display("FAIL counter_hold: got %h want %h", status, exp_status());
        end
    endtask

    task automatic test_abort();
        bit seen;
        seen = 0;
        address = 32'd7;
        command = {~m_ack, 27'd0, 4'd2};
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (mem_req) seen = 1;
        end
        total++; if (!seen) begin bad++; $display("FAIL abort_req: got no mem_req want mem_req"); end
        repeat (2) @(negedge clk);
        #2 rst = 1'b1; command = 32'd0;
        #1;
        total++;
        if ({status, data_out, mem_req, mem_we, mem_addr, mem_wdata, eng_start, eng_reset,
             eng_start_cc, eng_end_cc} !== '0) begin
            bad++; $display("FAIL abort_outputs: got status=%h mem_req=%b data_out=%h want zeros",
                            status, mem_req, data_out);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        repeat (5) @(negedge clk);
        address = 32'd5; data_in = 64'hA5A5_5A5A_0F0F_F0F0;
        run_cmd(32'h8000_0001, 1, 0, 0, 64'd0, 300);
        model_apply(32'h8000_0001, 32'd5, 32'd0, 32'd0, 0, 0, 0, 64'd0);
        total++; if (timed_out || n_req !== 1 || o_wdata !== 64'hA5A5_5A5A_0F0F_F0F0 || status !== 32'h0000_0110) begin
            bad++; $display("FAIL abort_reissue: got req=%0d wdata=%h status=%h want 1 a5a55a5a0f0ff0f0 00000110",
                            n_req, o_wdata, status);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_run();
        test_errors();
        test_pending();
        test_random();
        test_saturate();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
